bram_port_arbiter: RTL and testbench

- Shares port A of the byte-enable dual-port BRAM (BEDPBRAM2) between two requesters, m0 and m1.
- Typical pairing: m0 = UART loader, m1 = core/sequencer.
- Serialises their reads and column-masked writes, hides the RAM's 1-cycle read latency, and returns read data with a one-cycle ack pulse.
- Sits between the requesters and the RAM instance in Top; port B stays untouched.

---
 rtl/bram_port_arbiter_pkg.sv | 26 ++
 rtl/bram_arb_rr_picker.sv | 46 ++++
 rtl/bram_port_arbiter.sv | 164 ++++++++++++++++
 tb/tb_bram_port_arbiter.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/bram_port_arbiter_pkg.sv
// Shared definitions for the BRAM port-A arbiter: FSM state encodings,
// requester indices and the column-count helper.
package bram_port_arbiter_pkg;

  localparam int unsigned ADDR_W_DEFAULT  = 10;
  localparam int unsigned DATA_W_DEFAULT  = 32;
  localparam int unsigned COL_W_DEFAULT   = 8;

  // Transaction sequencing states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } arb_state_e;

  // Requester indices
  localparam logic M0 = 1'b0;
  localparam logic M1 = 1'b1;

  // Number of write-enable columns in one RAM word
  function automatic int unsigned columns(input int unsigned data_w, input int unsigned col_w);
    return data_w / col_w;
  endfunction

endpackage

// File: rtl/bram_arb_rr_picker.sv
// Two-requester winner selection. Default build: round-robin on ties using a
// registered last_grant (reset to M1 so m0 wins the first tie).
// Macro BRAM_ARB_FIXED_PRIORITY_EN: m0 always wins ties, no last_grant state.
module bram_arb_rr_picker
  import bram_port_arbiter_pkg::*;
(
  input  logic clk_i,
  input  logic rst_i,
  input  logic req0_i,
  input  logic req1_i,
  input  logic update_i,
  output logic winner_c_o
);

`ifdef BRAM_ARB_FIXED_PRIORITY_EN
  logic unused_inputs;
  assign unused_inputs = &{1'b0, clk_i, rst_i, update_i};

  // m0 wins whenever it asks; m1 only when alone
  always_comb begin
    winner_c_o = (req0_i || !req1_i) ? M0 : M1;
  end
`else
  logic last_grant_q;

  // Remember who was served last so a tie goes to the other one
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      last_grant_q <= M1;
    end else if (update_i) begin
      last_grant_q <= winner_c_o;
    end
  end

  // Sole requester wins; a tie goes to the one not granted last
  always_comb begin
    winner_c_o = M0;
    if (req0_i && req1_i) begin
      winner_c_o = ~last_grant_q;
    end else if (req1_i) begin
      winner_c_o = M1;
    end
  end
`endif

endmodule

// File: rtl/bram_port_arbiter.sv
// Shares BRAM port A between two requesters (m0, m1). Serialises reads and
// column-masked writes, absorbs the RAM's one-cycle read latency and returns
// a one-cycle ack per transaction. Tie policy: round-robin by default,
// fixed m0 priority when BRAM_ARB_FIXED_PRIORITY_EN is defined.
module bram_port_arbiter
  import bram_port_arbiter_pkg::*;
#(
  parameter int unsigned ADDRESS_BITWIDTH     = ADDR_W_DEFAULT,
  parameter int unsigned DATA_BITWIDTH        = DATA_W_DEFAULT,
  parameter int unsigned DATA_COLUMN_BITWIDTH = COL_W_DEFAULT
) (
  input  logic                                             sys_clk,
  input  logic                                             sys_rst,

  input  logic                                             m0_req,
  input  logic [DATA_BITWIDTH/DATA_COLUMN_BITWIDTH-1:0]    m0_write_enable,
  input  logic [ADDRESS_BITWIDTH-1:0]                      m0_address,
  input  logic [DATA_BITWIDTH-1:0]                         m0_data_in,
  output logic                                             m0_ack,
  output logic [DATA_BITWIDTH-1:0]                         m0_data_out,

  input  logic                                             m1_req,
  input  logic [DATA_BITWIDTH/DATA_COLUMN_BITWIDTH-1:0]    m1_write_enable,
  input  logic [ADDRESS_BITWIDTH-1:0]                      m1_address,
  input  logic [DATA_BITWIDTH-1:0]                         m1_data_in,
  output logic                                             m1_ack,
  output logic [DATA_BITWIDTH-1:0]                         m1_data_out,

  output logic [DATA_BITWIDTH/DATA_COLUMN_BITWIDTH-1:0]    ram_write_enable,
  output logic [ADDRESS_BITWIDTH-1:0]                      ram_address,
  output logic [DATA_BITWIDTH-1:0]                         ram_data_in,
  input  logic [DATA_BITWIDTH-1:0]                         ram_data_out,

  output logic                                             busy
);

  localparam int unsigned COLUMNS = columns(DATA_BITWIDTH, DATA_COLUMN_BITWIDTH);

  arb_state_e                  state_q, state_d;
  logic                        grant_q, grant_d;
  logic                        is_write_q, is_write_d;
  logic [COLUMNS-1:0]          ram_we_q, ram_we_d;
  logic [ADDRESS_BITWIDTH-1:0] ram_addr_q, ram_addr_d;
  logic [DATA_BITWIDTH-1:0]    ram_din_q, ram_din_d;
  logic                        m0_ack_q, m0_ack_d;
  logic                        m1_ack_q, m1_ack_d;
  logic [DATA_BITWIDTH-1:0]    m0_dout_q, m0_dout_d;
  logic [DATA_BITWIDTH-1:0]    m1_dout_q, m1_dout_d;
  logic                        busy_q, busy_d;
  logic                        pick_update;
  logic                        winner;

  bram_arb_rr_picker u_picker (
    .clk_i      (sys_clk),
    .rst_i      (sys_rst),
    .req0_i     (m0_req),
    .req1_i     (m1_req),
    .update_i   (pick_update),
    .winner_c_o (winner)
  );

  // State and output registers
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q    <= ST_IDLE;
      grant_q    <= M0;
      is_write_q <= 1'b0;
      ram_we_q   <= '0;
      ram_addr_q <= '0;
      ram_din_q  <= '0;
      m0_ack_q   <= 1'b0;
      m1_ack_q   <= 1'b0;
      m0_dout_q  <= '0;
      m1_dout_q  <= '0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      is_write_q <= is_write_d;
      ram_we_q   <= ram_we_d;
      ram_addr_q <= ram_addr_d;
      ram_din_q  <= ram_din_d;
      m0_ack_q   <= m0_ack_d;
      m1_ack_q   <= m1_ack_d;
      m0_dout_q  <= m0_dout_d;
      m1_dout_q  <= m1_dout_d;
      busy_q     <= busy_d;
    end
  end

  // Next-state and next-output logic; acks are set on the edge entering DONE
  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    is_write_d  = is_write_q;
    ram_we_d    = ram_we_q;
    ram_addr_d  = ram_addr_q;
    ram_din_d   = ram_din_q;
    m0_ack_d    = 1'b0;
    m1_ack_d    = 1'b0;
    m0_dout_d   = m0_dout_q;
    m1_dout_d   = m1_dout_q;
    pick_update = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (m0_req || m1_req) begin
          grant_d     = winner;
          pick_update = 1'b1;
          if (winner == M1) begin
            ram_we_d   = m1_write_enable;
            ram_addr_d = m1_address;
            ram_din_d  = m1_data_in;
            is_write_d = |m1_write_enable;
          end else begin
            ram_we_d   = m0_write_enable;
            ram_addr_d = m0_address;
            ram_din_d  = m0_data_in;
            is_write_d = |m0_write_enable;
          end
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        ram_we_d = '0;
        if (is_write_q) begin
          m0_ack_d = (grant_q == M0);
          m1_ack_d = (grant_q == M1);
          state_d  = ST_DONE;
        end else begin
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (grant_q == M1) begin
          m1_dout_d = ram_data_out;
          m1_ack_d  = 1'b1;
        end else begin
          m0_dout_d = ram_data_out;
          m0_ack_d  = 1'b1;
        end
        state_d = ST_DONE;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  assign ram_write_enable = ram_we_q;
  assign ram_address      = ram_addr_q;
  assign ram_data_in      = ram_din_q;
  assign m0_ack           = m0_ack_q;
  assign m1_ack           = m1_ack_q;
  assign m0_data_out      = m0_dout_q;
  assign m1_data_out      = m1_dout_q;
  assign busy             = busy_q;

endmodule

// File: tb/tb_bram_port_arbiter.sv
// Directed bench for bram_port_arbiter with a byte-enable RAM model on port A.
module tb_bram_port_arbiter;

  logic        clk;
  logic        rst;
  logic        m0_req, m1_req;
  logic [3:0]  m0_we, m1_we;
  logic [9:0]  m0_addr, m1_addr;
  logic [31:0] m0_din, m1_din;
  logic        m0_ack, m1_ack;
  logic [31:0] m0_dout, m1_dout;
  logic [3:0]  ram_we;
  logic [9:0]  ram_addr;
  logic [31:0] ram_din;
  logic [31:0] ram_dout;
  logic        busy;

  int n_checks;
  int n_fail;

  bram_port_arbiter dut (
    .sys_clk          (clk),
    .sys_rst          (rst),
    .m0_req           (m0_req),
    .m0_write_enable  (m0_we),
    .m0_address       (m0_addr),
    .m0_data_in       (m0_din),
    .m0_ack           (m0_ack),
    .m0_data_out      (m0_dout),
    .m1_req           (m1_req),
    .m1_write_enable  (m1_we),
    .m1_address       (m1_addr),
    .m1_data_in       (m1_din),
    .m1_ack           (m1_ack),
    .m1_data_out      (m1_dout),
    .ram_write_enable (ram_we),
    .ram_address      (ram_addr),
    .ram_data_in      (ram_din),
    .ram_data_out     (ram_dout),
    .busy             (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM model: byte-column writes, registered read (read-before-write)
  logic [31:0] mem [1024];
  logic        mem_clr;
  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 1024; i++) mem[i] <= '0;
    end else begin
      for (int c = 0; c < 4; c++)
        if (ram_we[c]) mem[ram_addr][c*8 +: 8] <= ram_din[c*8 +: 8];
    end
    ram_dout <= mem[ram_addr];
  end

  // Write-strobe monitor
  int         we_cycles;
  logic [3:0] last_we;
  logic [9:0] last_we_addr;
  always @(negedge clk) begin
    if (ram_we != 4'b0000) begin
      we_cycles    <= we_cycles + 1;
      last_we      <= ram_we;
      last_we_addr <= ram_addr;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic apply_reset();
    @(negedge clk);
    m0_req = 1'b0;
    m1_req = 1'b0;
    rst    = 1'b1;
    @(negedge clk);
    rst    = 1'b0;
  endtask

  // One transaction from requester sel; lat = cycles from accept edge to ack (0 = timeout)
  task automatic txn(input logic sel, input logic [3:0] we, input logic [9:0] a,
                     input logic [31:0] d, output int lat, output logic [31:0] q);
    @(negedge clk);
    if (sel) begin
      m1_we = we; m1_addr = a; m1_din = d; m1_req = 1'b1;
    end else begin
      m0_we = we; m0_addr = a; m0_din = d; m0_req = 1'b1;
    end
    lat = 0;
    q   = '0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (sel ? m1_ack : m0_ack) begin
        lat = i;
        q   = sel ? m1_dout : m0_dout;
        break;
      end
    end
    if (sel) m1_req = 1'b0;
    else     m0_req = 1'b0;
  endtask

  int          lat;
  logic [31:0] q;
  int          c0, c1, n, n1, last_cyc;
  logic [31:0] d0, d1;
  logic [5:0]  seq;
  logic [5:0]  exp_seq;
  int          exp_m1_acks;

  initial begin
    rst = 1'b1; mem_clr = 1'b1;
    m0_req = 0; m1_req = 0;
    m0_we = 0; m1_we = 0; m0_addr = 0; m1_addr = 0; m0_din = 0; m1_din = 0;
    n_checks = 0; n_fail = 0; we_cycles = 0; last_we = 0; last_we_addr = 0;

    // Reset values
    @(negedge clk);
    @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_ram_we", 32'(ram_we), 32'd0);
    check("rst_ram_addr", 32'(ram_addr), 32'd0);
    check("rst_ram_din", ram_din, 32'd0);
    check("rst_acks", 32'({m0_ack, m1_ack}), 32'd0);
    check("rst_douts", m0_dout | m1_dout, 32'd0);
    mem_clr = 1'b0;
    rst = 1'b0;

    // Partial-mask write then read back
    we_cycles = 0;
    txn(1'b0, 4'b0001, 10'd5, 32'habcd_ef12, lat, q);
    check("wr_lat", 32'(lat), 32'd2);
    @(negedge clk);
    check("wr_we_cycles", 32'(we_cycles), 32'd1);
    check("wr_we_mask", 32'(last_we), 32'h1);
    check("wr_we_addr", 32'(last_we_addr), 32'd5);
    txn(1'b0, 4'b0000, 10'd5, 32'h0, lat, q);
    check("rd_lat", 32'(lat), 32'd3);
    check("rd_data", q, 32'h0000_0012);

    // Simultaneous reads from reset
    txn(1'b0, 4'b1111, 10'd1, 32'h1111_0001, lat, q);
    txn(1'b0, 4'b1111, 10'd2, 32'h2222_0002, lat, q);
    apply_reset();
    @(negedge clk);
    m0_we = 0; m0_addr = 10'd1; m0_req = 1'b1;
    m1_we = 0; m1_addr = 10'd2; m1_req = 1'b1;
    c0 = 0; c1 = 0; d0 = 0; d1 = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (m0_ack) begin
        c0 = i; d0 = m0_dout; m0_req = 1'b0;
        check("tie_m1_dout_held", m1_dout, 32'h0);
      end
      if (m1_ack) begin
        c1 = i; d1 = m1_dout; m1_req = 1'b0;
      end
      if (c1 != 0) break;
    end
    m0_req = 1'b0; m1_req = 1'b0;
    check("tie_m0_ack_cyc", 32'(c0), 32'd3);
    check("tie_m1_ack_cyc", 32'(c1), 32'd7);
    check("tie_m0_data", d0, 32'h1111_0001);
    check("tie_m1_data", d1, 32'h2222_0002);

    // Continuous requests from both: six grants
    apply_reset();
    @(negedge clk);
    m0_we = 4'b1111; m0_addr = 10'd40; m0_din = 32'h4040_4040; m0_req = 1'b1;
    m1_we = 4'b1111; m1_addr = 10'd41; m1_din = 32'h4141_4141; m1_req = 1'b1;
    seq = '0; n = 0; n1 = 0; last_cyc = 0;
    for (int i = 1; i <= 60; i++) begin
      @(negedge clk);
      if (m0_ack || m1_ack) begin
        if (m1_ack) begin
          seq[n] = 1'b1;
          n1++;
        end
        n++;
        if (n == 6) begin
          last_cyc = i;
          break;
        end
      end
    end
    m0_req = 1'b0; m1_req = 1'b0;
`ifdef BRAM_ARB_FIXED_PRIORITY_EN
    exp_seq = 6'b000000; exp_m1_acks = 0;
`else
    exp_seq = 6'b101010; exp_m1_acks = 3;
`endif
    check("rr_seq", 32'(seq), 32'(exp_seq));
    check("rr_m1_acks", 32'(n1), 32'(exp_m1_acks));
    check("rr_last_cyc", 32'(last_cyc), 32'd17);
    repeat (6) @(negedge clk);
    check("rr_idle_after", 32'(busy), 32'd0);

    // m1 drops req right after acceptance and changes its fields
    apply_reset();
    @(negedge clk);
    m1_we = 4'b1111; m1_addr = 10'd9; m1_din = 32'hcafe_0009; m1_req = 1'b1;
    @(negedge clk);
    m1_req = 1'b0; m1_addr = 10'd10; m1_din = 32'hdead_beef;
    n1 = 0; c1 = 0;
    for (int i = 2; i <= 10; i++) begin
      @(negedge clk);
      if (m1_ack) begin
        n1++; c1 = i;
      end
    end
    check("drop_ack_count", 32'(n1), 32'd1);
    check("drop_ack_cyc", 32'(c1), 32'd2);
    check("drop_busy", 32'(busy), 32'd0);
    txn(1'b1, 4'b0000, 10'd9, 32'h0, lat, q);
    check("drop_rd9", q, 32'hcafe_0009);
    txn(1'b1, 4'b0000, 10'd10, 32'h0, lat, q);
    check("drop_rd10", q, 32'h0);

    // Reset during WAIT of an m0 read
    apply_reset();
    @(negedge clk);
    m0_we = 0; m0_addr = 10'd9; m0_req = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("mid_busy_wait", 32'(busy), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_ack", 32'(m0_ack), 32'd0);
    check("mid_rst_we", 32'(ram_we), 32'd0);
    check("mid_rst_dout", m0_dout, 32'd0);
    m0_req = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    n = 0;
    repeat (5) begin
      @(negedge clk);
      if (m0_ack) n++;
    end
    check("mid_no_m0_ack", 32'(n), 32'd0);
    txn(1'b1, 4'b1111, 10'd20, 32'h5a5a_a5a5, lat, q);
    check("mid_m1_wr_lat", 32'(lat), 32'd2);
    txn(1'b1, 4'b0000, 10'd20, 32'h0, lat, q);
    check("mid_m1_rd", q, 32'h5a5a_a5a5);

    // Full write then top-column overwrite
    txn(1'b0, 4'b1111, 10'd30, 32'h1234_5678, lat, q);
    txn(1'b0, 4'b1000, 10'd30, 32'hff00_0000, lat, q);
    txn(1'b0, 4'b0000, 10'd30, 32'h0, lat, q);
    check("col_merge", q, 32'hff34_5678);
    check("col_rd_lat", 32'(lat), 32'd3);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
